// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer scan-out reader.
package fb_pkg;

  localparam int FB_W   = 240;
  localparam int FB_H   = 160;
  localparam int WIN_X0 = 80;
  localparam int WIN_Y0 = 80;
  localparam int TAG_W  = 8;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef logic [18:0] fb_addr_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/fb_line_buffer.sv
// One framebuffer row of pixels: simple dual-port RAM, one write port, registered read.
module fb_line_buffer
  import fb_pkg::*;
#(
  parameter int DEPTH = FB_W,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fb_scanout_reader.sv
// Prefetches framebuffer rows into ping-pong line buffers and scans them out pixel-doubled.
// Optional FB_SCANOUT_BORDER_EN paints pixels outside the window with BORDER_COLOR.
module fb_scanout_reader #(
  parameter int          FB_W         = fb_pkg::FB_W,
  parameter int          FB_H         = fb_pkg::FB_H,
  parameter int          WIN_X0       = fb_pkg::WIN_X0,
  parameter int          WIN_Y0       = fb_pkg::WIN_Y0,
  parameter logic [23:0] BORDER_COLOR = 24'h000000
) (
  input  logic        VGACLK,
  input  logic        Reset,
  input  logic [9:0]  DRAWX,
  input  logic [9:0]  DRAWY,
  input  logic [23:0] fb_rdata,
  output logic [18:0] fb_raddr,
  output logic        fb_port_free,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        underrun
);
  import fb_pkg::*;

  localparam int CW      = $clog2(FB_W);
  localparam int TRIG_Y0 = WIN_Y0 - 2;
  localparam int TRIG_YN = TRIG_Y0 + 2 * (FB_H - 1);
  localparam int WIN_X1  = WIN_X0 + 2 * FB_W;
  localparam int WIN_Y1  = WIN_Y0 + 2 * FB_H;

  fetch_state_t     state, next_state;
  logic             trigger, fetch_active, drain;
  logic             trig_hit, fetch_last;
  logic [9:0]       trig_dy;
  logic [TAG_W-1:0] trig_row;
  logic [CW-1:0]    fetch_col;
  logic [TAG_W-1:0] fetch_row;
  logic             fetch_buf;
  logic             cap_en;
  logic [CW-1:0]    cap_col;
  logic [1:0]       buf_valid;
  logic [TAG_W-1:0] buf_tag [2];
  logic             in_win, disp_hit, disp_buf;
  logic [9:0]       win_dx, win_dy;
  logic [CW-1:0]    disp_col;
  logic [TAG_W-1:0] disp_row;
  logic             hit_q, sel_q;
  logic [23:0]      rd_data0, rd_data1;
  rgb_t             pix;

  always_comb begin
    trig_dy = '0;
    if (DRAWY >= 10'(TRIG_Y0)) trig_dy = DRAWY - 10'(TRIG_Y0);
    trig_row   = TAG_W'(trig_dy >> 1);
    trig_hit   = (DRAWX == '0) && (DRAWY >= 10'(TRIG_Y0)) &&
                 (DRAWY <= 10'(TRIG_YN)) && !trig_dy[0];
    fetch_last = (fetch_col == CW'(FB_W - 1));
  end

  always_ff @(posedge VGACLK or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (trig_hit) next_state = S_FETCH;
      S_FETCH: if (fetch_last) next_state = S_DRAIN;
      S_DRAIN: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    trigger      = 1'b0;
    fetch_active = 1'b0;
    drain        = 1'b0;
    fb_port_free = 1'b0;
    case (state)
      S_IDLE: begin
        fb_port_free = 1'b1;
        trigger      = trig_hit;
      end
      S_FETCH: fetch_active = 1'b1;
      S_DRAIN: drain = 1'b1;
      default: fb_port_free = 1'b1;
    endcase
  end

  // Address generator; fb_raddr keeps the last fetch address between fetches.
  always_ff @(posedge VGACLK or negedge Reset) begin
    if (!Reset) begin
      fb_raddr  <= '0;
      fetch_col <= '0;
      fetch_row <= '0;
      fetch_buf <= 1'b0;
    end else if (trigger) begin
      fb_raddr  <= fb_addr_t'(trig_row) * fb_addr_t'(FB_W);
      fetch_col <= '0;
      fetch_row <= trig_row;
      fetch_buf <= trig_row[0];
    end else if (fetch_active && !fetch_last) begin
      fb_raddr  <= fb_raddr + 19'd1;
      fetch_col <= fetch_col + CW'(1);
    end
  end

  always_ff @(posedge VGACLK or negedge Reset) begin
    if (!Reset) begin
      cap_en  <= 1'b0;
      cap_col <= '0;
    end else begin
      cap_en  <= fetch_active;
      cap_col <= fetch_col;
    end
  end

  // The frame-start clear wins over a fetch completing on the same edge.
  always_ff @(posedge VGACLK or negedge Reset) begin
    if (!Reset) begin
      buf_valid  <= '0;
      buf_tag[0] <= '0;
      buf_tag[1] <= '0;
    end else begin
      if (drain) begin
        buf_valid[fetch_buf] <= 1'b1;
        buf_tag[fetch_buf]   <= fetch_row;
      end
      if (DRAWX == '0 && DRAWY == '0) buf_valid <= '0;
    end
  end

  fb_line_buffer #(.DEPTH(FB_W), .WIDTH(24)) u_buf0 (
    .clk   (VGACLK),
    .we    (cap_en && !fetch_buf),
    .waddr (cap_col),
    .wdata (fb_rdata),
    .raddr (disp_col),
    .rdata (rd_data0)
  );

  fb_line_buffer #(.DEPTH(FB_W), .WIDTH(24)) u_buf1 (
    .clk   (VGACLK),
    .we    (cap_en && fetch_buf),
    .waddr (cap_col),
    .wdata (fb_rdata),
    .raddr (disp_col),
    .rdata (rd_data1)
  );

  always_comb begin
    in_win = (DRAWX >= 10'(WIN_X0)) && (DRAWX < 10'(WIN_X1)) &&
             (DRAWY >= 10'(WIN_Y0)) && (DRAWY < 10'(WIN_Y1));
    win_dx = '0;
    win_dy = '0;
    if (in_win) begin
      win_dx = DRAWX - 10'(WIN_X0);
      win_dy = DRAWY - 10'(WIN_Y0);
    end
    disp_col = CW'(win_dx >> 1);
    disp_row = TAG_W'(win_dy >> 1);
    disp_buf = disp_row[0];
    disp_hit = in_win && buf_valid[disp_buf] && (buf_tag[disp_buf] == disp_row);
  end

  always_ff @(posedge VGACLK or negedge Reset) begin
    if (!Reset) begin
      hit_q    <= 1'b0;
      sel_q    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      hit_q    <= disp_hit;
      sel_q    <= disp_buf;
      underrun <= in_win && !disp_hit;
    end
  end

`ifdef FB_SCANOUT_BORDER_EN
  logic border_q;

  always_ff @(posedge VGACLK or negedge Reset) begin
    if (!Reset) border_q <= 1'b0;
    else        border_q <= !in_win;
  end
`endif

  // Every selector here is a flop, so the pixel changes only just after the clock edge.
  always_comb begin
    pix = '0;
    if (hit_q) pix = sel_q ? rgb_t'(rd_data1) : rgb_t'(rd_data0);
`ifdef FB_SCANOUT_BORDER_EN
    else if (border_q) pix = rgb_t'(BORDER_COLOR);
`endif
  end

  assign R = pix.r;
  assign G = pix.g;
  assign B = pix.b;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Self-checking bench for fb_scanout_reader: drives a compressed raster, models the framebuffer
// and compares every output cycle against a row-tag level reference model.
module tb_fb_scanout_reader;

  localparam int FB_W   = 240;
  localparam int FB_H   = 160;
  localparam int WIN_X0 = 80;
  localparam int WIN_Y0 = 80;
`ifdef FB_SCANOUT_BORDER_EN
  localparam logic [23:0] BORDER_EXP = 24'h203040;
`else
  localparam logic [23:0] BORDER_EXP = 24'h000000;
`endif

  logic        VGACLK;
  logic        Reset;
  logic [9:0]  DRAWX, DRAWY;
  logic [23:0] fb_rdata;
  logic [18:0] fb_raddr;
  logic        fb_port_free;
  logic [7:0]  R, G, B;
  logic        underrun;

  fb_scanout_reader #(.BORDER_COLOR(24'h203040)) dut (
    .VGACLK       (VGACLK),
    .Reset        (Reset),
    .DRAWX        (DRAWX),
    .DRAWY        (DRAWY),
    .fb_rdata     (fb_rdata),
    .fb_raddr     (fb_raddr),
    .fb_port_free (fb_port_free),
    .R            (R),
    .G            (G),
    .B            (B),
    .underrun     (underrun)
  );

  initial VGACLK = 1'b0;
  always #5 VGACLK = ~VGACLK;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  salt;
  logic [18:0] prev_addr;
  logic [23:0] last_rgb;
  logic        last_und;
  int          low_cnt, first_addr, last_addr;

  // Reference model: which framebuffer row each buffer holds, plus a fetch countdown.
  int          m_busy;
  int          m_row;
  bit          m_valid [2];
  int          m_tag [2];
  logic [7:0]  m_salt [2];
  logic [7:0]  m_fetch_salt;
  logic [18:0] m_addr;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (DRAWX=%0d DRAWY=%0d t=%0t)",
               tag, got, exp, DRAWX, DRAWY, $time);
    end
  endtask

  function automatic logic [23:0] mem_word(input logic [18:0] a);
    int ai;
    ai = int'(a);
    return {8'(ai / FB_W), 8'(ai % FB_W), salt};
  endfunction

  task automatic model_reset();
    m_busy     = 0;
    m_row      = 0;
    m_valid[0] = 0;
    m_valid[1] = 0;
    m_tag[0]   = 0;
    m_tag[1]   = 0;
    m_addr     = '0;
  endtask

  task automatic applyStimulus(input int x, input int y);
    logic [23:0] e_rgb;
    logic        e_und;
    int          row, col, b, j;
    bit          idle_before;
    DRAWX = 10'(x);
    DRAWY = 10'(y);
    e_rgb = '0;
    e_und = 1'b0;
    if (!Reset) begin
      model_reset();
    end else begin
      if (x >= WIN_X0 && x < WIN_X0 + 2*FB_W && y >= WIN_Y0 && y < WIN_Y0 + 2*FB_H) begin
        row = (y - WIN_Y0) / 2;
        col = (x - WIN_X0) / 2;
        b   = row % 2;
        if (m_valid[b] && m_tag[b] == row) e_rgb = {8'(row), 8'(col), m_salt[b]};
        else e_und = 1'b1;
      end else begin
        e_rgb = BORDER_EXP;
      end
      idle_before = (m_busy == 0);
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_valid[m_row % 2] = 1;
          m_tag[m_row % 2]   = m_row;
          m_salt[m_row % 2]  = m_fetch_salt;
        end
      end
      if (idle_before && x == 0 && y >= WIN_Y0 - 2 && y <= WIN_Y0 - 2 + 2*(FB_H-1) && (y % 2) == 0) begin
        m_row        = (y - (WIN_Y0 - 2)) / 2;
        m_busy       = FB_W + 1;
        m_fetch_salt = salt;
      end
      if (x == 0 && y == 0) begin
        m_valid[0] = 0;
        m_valid[1] = 0;
      end
      if (m_busy > 0) begin
        j = FB_W + 1 - m_busy;
        if (j > FB_W - 1) j = FB_W - 1;
        m_addr = 19'(m_row * FB_W + j);
      end
    end
    @(posedge VGACLK);
    #1;
    fb_rdata  = mem_word(prev_addr);
    prev_addr = fb_raddr;
    checkOutput("rgb", {8'h0, R, G, B}, {8'h0, e_rgb});
    checkOutput("underrun", {31'h0, underrun}, {31'h0, e_und});
    checkOutput("port_free", {31'h0, fb_port_free}, {31'h0, (m_busy == 0)});
    checkOutput("raddr", {13'h0, fb_raddr}, {13'h0, m_addr});
    last_rgb = {R, G, B};
    last_und = underrun;
    if (!fb_port_free) begin
      if (low_cnt == 0) first_addr = int'(fb_raddr);
      last_addr = int'(fb_raddr);
      low_cnt++;
    end
  endtask

  task automatic run_line(input int y, input bit sweep, input int n_rand);
    int fixed_x [7] = '{79, 80, 81, 558, 559, 560, 10};
    low_cnt = 0;
    applyStimulus(0, y);
    if (sweep) for (int x = 1; x <= FB_W + 1; x++) applyStimulus(x, y);
    foreach (fixed_x[i]) applyStimulus(fixed_x[i], y);
    for (int i = 0; i < n_rand; i++) applyStimulus(int'($urandom_range(1, 799)), y);
  endtask

  task automatic reset_pulse();
    Reset = 1'b0;
    #2;
    model_reset();
    checkOutput("rst_port_free", {31'h0, fb_port_free}, 32'h1);
    checkOutput("rst_raddr", {13'h0, fb_raddr}, 32'h0);
    checkOutput("rst_rgb", {8'h0, R, G, B}, 32'h0);
    checkOutput("rst_underrun", {31'h0, underrun}, 32'h0);
    Reset = 1'b1;
  endtask

  initial begin
    Reset     = 1'b1;
    DRAWX     = '0;
    DRAWY     = 10'd500;
    fb_rdata  = '0;
    salt      = 8'h5A;
    prev_addr = '0;
    low_cnt   = 0;
    model_reset();
    #2 Reset = 1'b0;
    applyStimulus(100, 500);
    applyStimulus(200, 100);
    checkOutput("reset_rgb", {8'h0, R, G, B}, 32'h0);
    checkOutput("reset_underrun", {31'h0, underrun}, 32'h0);
    checkOutput("reset_port_free", {31'h0, fb_port_free}, 32'h1);
    checkOutput("reset_raddr", {13'h0, fb_raddr}, 32'h0);
    Reset = 1'b1;

    $display("[TB] frame with fixed pattern");
    applyStimulus(0, 0);
    for (int y = 76; y <= 402; y++) begin
      run_line(y, (y >= 78 && y <= 396 && (y % 2) == 0), 4);
      if (y == 78) begin
        checkOutput("l78_low_cycles", low_cnt, 241);
        checkOutput("l78_first_addr", first_addr, 0);
        checkOutput("l78_last_addr", last_addr, 239);
      end
      if (y == 80) begin
        checkOutput("l80_first_addr", first_addr, 240);
        checkOutput("l80_last_addr", last_addr, 479);
        applyStimulus(80, 80);
        checkOutput("px_80_80", last_rgb, 24'h00005A);
      end
      if (y == 81) begin
        applyStimulus(81, 81);
        checkOutput("px_81_81", last_rgb, 24'h00005A);
      end
      if (y == 399) begin
        applyStimulus(559, 399);
        checkOutput("px_399_559", last_rgb, 24'h9FEF5A);
      end
    end
    applyStimulus(10, 10);
    checkOutput("px_border_10_10", last_rgb, BORDER_EXP);

    $display("[TB] frame with fetch of row 0 suppressed by reset");
    salt = 8'($urandom);
    applyStimulus(0, 0);
    run_line(76, 0, 4);
    run_line(77, 0, 4);
    Reset = 1'b0;
    run_line(78, 1, 4);
    Reset = 1'b1;
    for (int y = 79; y <= 85; y++) begin
      run_line(y, ((y % 2) == 0), 4);
      if (y == 80) begin
        applyStimulus(100, 80);
        checkOutput("ur_px_l80", last_rgb, 24'h0);
        checkOutput("ur_pulse_l80", last_und, 1);
      end
      if (y == 82) begin
        applyStimulus(84, 82);
        checkOutput("px_after_ur", last_rgb, {8'd1, 8'd2, salt});
      end
    end

    $display("[TB] reset in the middle of a fetch");
    salt = 8'($urandom);
    applyStimulus(0, 0);
    run_line(76, 0, 2);
    applyStimulus(0, 78);
    for (int x = 1; x < 100; x++) applyStimulus(x, 78);
    reset_pulse();
    for (int x = 100; x <= FB_W + 1; x++) applyStimulus(x, 78);
    run_line(78, 1, 2);
    run_line(79, 0, 2);
    applyStimulus(90, 80);
    checkOutput("px_refetch", last_rgb, {8'd0, 8'd5, salt});

    $display("[TB] raster wrap during a fetch");
    salt = 8'($urandom);
    applyStimulus(0, 78);
    for (int i = 0; i < 3; i++) applyStimulus(5 + i, 78);
    applyStimulus(0, 0);
    for (int i = 0; i < FB_W - 3; i++) applyStimulus(int'($urandom_range(1, 799)), 0);
    applyStimulus(1, 79);
    applyStimulus(82, 80);
    checkOutput("px_after_wrap", last_rgb, {8'd0, 8'd1, salt});

    $display("[TB] trigger while busy");
    applyStimulus(0, 78);
    for (int x = 5; x < 10; x++) applyStimulus(x, 78);
    applyStimulus(0, 82);
    for (int i = 0; i < FB_W - 5; i++) applyStimulus(int'($urandom_range(1, 799)), 82);
    checkOutput("busy_trig_raddr", {13'h0, fb_raddr}, 32'd239);
    checkOutput("busy_trig_free", {31'h0, fb_port_free}, 32'h1);

    $display("[TB] random line order");
    for (int n = 0; n < 20; n++) begin
      if ((n % 5) == 0) salt = 8'($urandom);
      if ((n % 7) == 3) applyStimulus(0, 0);
      run_line(int'($urandom_range(76, 403)), 1, 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
